// File: rtl/mem_xfer_pkg.sv
// mem_xfer_pkg: shared types and sizing defaults for the memory transfer datapath.
package mem_xfer_pkg;
    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 3;
    localparam int DEPTH = 1 << ADDR_W_DEF;
    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} xfer_state_t;
endpackage

// File: rtl/out_fifo2.sv
// out_fifo2: two-entry FIFO with the head word presented directly on head.
module out_fifo2 import mem_xfer_pkg::*; #(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] head,
    output logic [1:0]        occ
);
    logic [DATA_W-1:0] tail;
    logic              do_pop;
    logic [1:0]        slot;
    assign do_pop = pop && occ != 2'd0;
    // slot is where an incoming word lands once this cycle's pop has shifted the queue
    assign slot = occ - 2'(do_pop);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head <= '0;
            tail <= '0;
            occ  <= '0;
        end else begin
            head <= (push && slot == 2'd0) ? din : do_pop ? tail : head;
            tail <= (push && slot == 2'd1) ? din : tail;
            occ  <= occ + 2'(push) - 2'(do_pop);
        end
    end
endmodule

// File: rtl/mem_read_streamer.sv
// mem_read_streamer: reads a programmed run of words from a synchronous memory
// and streams them over valid/ready, buffering to hide the read latency.
module mem_read_streamer import mem_xfer_pkg::*; #(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] baseAddr,
    input  logic [ADDR_W:0]   len,
    output logic              memRe,
    output logic [ADDR_W-1:0] memAddr,
    input  logic [DATA_W-1:0] memData,
    output logic [DATA_W-1:0] dataOut,
    output logic              dataValid,
    input  logic              dataReady,
    output logic              busy,
    output logic              done
);
    xfer_state_t state;
    logic [ADDR_W:0] rem;
    logic            inflight;
    logic            pop;
    logic [1:0]      occ;
    assign dataValid = occ != 2'd0;
    assign pop       = dataValid && dataReady;
    assign busy      = state != IDLE;
    assign done      = state == DONE;
    // a read is only issued when its word is guaranteed a buffer slot one cycle later
    assign memRe = state == READ && (3'(occ) + 3'(inflight) - 3'(pop)) < 3'd2;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            memAddr  <= '0;
            rem      <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= memRe;
            unique case (state)
                IDLE: if (start) begin
                    memAddr <= baseAddr;
                    rem     <= len;
                    state   <= (len != '0) ? READ : DONE;
                end
                READ: if (memRe) begin
                    memAddr <= memAddr + 1'b1;
                    rem     <= rem - 1'b1;
                    if (rem == (ADDR_W+1)'(1)) state <= DRAIN;
                end
                DRAIN: if (!inflight && occ == 2'(pop)) state <= DONE;
                DONE: state <= IDLE;
            endcase
        end
    end
    out_fifo2 #(.DATA_W(DATA_W)) u_fifo (
        .clk  (clk),
        .rst_n(rst_n),
        .push (inflight),
        .pop  (pop),
        .din  (memData),
        .head (dataOut),
        .occ  (occ)
    );
endmodule

// File: tb/tb_mem_read_streamer.sv
// tb_mem_read_streamer: table-driven transfers with address/data scoreboards,
// plus hand-written reset-abort sequence.
module tb_mem_read_streamer;
    import mem_xfer_pkg::*;
    localparam int DW = 8;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] baseAddr = '0;
    logic [AW:0]   len = '0;
    logic          memRe;
    logic [AW-1:0] memAddr;
    logic [DW-1:0] memData = '0;
    logic [DW-1:0] dataOut;
    logic          dataValid;
    logic          dataReady = 1'b1;
    logic          busy;
    logic          done;

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] exp_q [$];
    logic [AW-1:0] addr_q [$];
    int errors = 0, checks = 0, max_occ = 0;
    int re_cnt, first_re, last_re, first_valid;
    logic prev_valid, prev_ready;
    logic [DW-1:0] prev_data;

    typedef struct {
        logic [AW-1:0] base;
        logic [AW:0]   n;
        logic [3:0]    pat;
        int            done_exp;
        int            restart;
    } vec_t;
    vec_t vecs [6];

    always #5 clk = ~clk;
    always @(posedge clk) if (memRe) memData <= mem[memAddr];

    mem_read_streamer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .baseAddr (baseAddr),
        .len      (len),
        .memRe    (memRe),
        .memAddr  (memAddr),
        .memData  (memData),
        .dataOut  (dataOut),
        .dataValid(dataValid),
        .dataReady(dataReady),
        .busy     (busy),
        .done     (done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_run();
        re_cnt = 0; first_re = -1; last_re = -1; first_valid = -1;
        prev_valid = 1'b0; prev_ready = 1'b0; prev_data = '0;
    endtask

    task automatic sample(input int cyc);
        @(negedge clk);
        if (int'(dut.occ) > max_occ) max_occ = int'(dut.occ);
        if (memRe) begin
            re_cnt++;
            if (first_re < 0) first_re = cyc;
            last_re = cyc;
            if (addr_q.size() == 0) check("extra_read", 1, 0);
            else check("mem_addr", 32'(memAddr), 32'(addr_q.pop_front()));
        end
        if (dataValid && first_valid < 0) first_valid = cyc;
        if (prev_valid && !prev_ready) check("hold_data", {dataValid, dataOut}, {1'b1, prev_data});
        if (dataValid && dataReady) begin
            if (exp_q.size() == 0) check("extra_word", 1, 0);
            else check("data_out", 32'(dataOut), 32'(exp_q.pop_front()));
        end
        prev_valid = dataValid; prev_ready = dataReady; prev_data = dataOut;
    endtask

    task automatic load_expect(input logic [AW-1:0] b, input logic [AW:0] n);
        exp_q.delete(); addr_q.delete();
        for (int i = 0; i < int'(n); i++) begin
            logic [AW-1:0] a;
            a = b + AW'(i);
            addr_q.push_back(a);
            exp_q.push_back(mem[a]);
        end
    endtask

    task automatic run_xfer(input logic [AW-1:0] b, input logic [AW:0] n, input logic [3:0] pat,
                            input int done_exp, input int restart);
        int done_cyc;
        clear_run();
        load_expect(b, n);
        start = 1'b1; baseAddr = b; len = n; dataReady = 1'b1;
        sample(0);
        check("idle_busy", 32'(busy), 0);
        @(posedge clk); #1;
        done_cyc = -1;
        for (int c = 1; c <= 60 && done_cyc < 0; c++) begin
            dataReady = pat[3 - ((c - 1) % 4)];
            if (c == restart) begin
                start = 1'b1; baseAddr = b + 3'd3; len = 4'd5;
            end else start = 1'b0;
            sample(c);
            if (c == 1) check("busy_rise", 32'(busy), 1);
            if (done) done_cyc = c;
            @(posedge clk); #1;
        end
        start = 1'b0;
        sample(done_cyc + 1);
        check("busy_fall", {busy, done}, 0);
        @(posedge clk); #1;
        check("done_seen", 32'(done_cyc >= 0), 1);
        if (done_exp > 0) check("done_cycle", done_cyc, done_exp);
        check("words_left", exp_q.size(), 0);
        check("reads_issued", re_cnt, 32'(n));
        check("first_valid", first_valid, (n == 0) ? -1 : 3);
        if (pat == 4'hF && n != 0) check("read_window", first_re * 100 + last_re, 100 + int'(n));
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'h10 + 8'(i);
        vecs[0] = '{3'd0, 4'd8, 4'hF, 11, 0};
        vecs[1] = '{3'd6, 4'd4, 4'hF, 7, 0};
        vecs[2] = '{3'd0, 4'd0, 4'hF, 1, 0};
        vecs[3] = '{3'd0, 4'd8, 4'b1001, 0, 0};
        vecs[4] = '{3'd3, 4'd1, 4'hF, 4, 0};
        vecs[5] = '{3'd1, 4'd4, 4'hF, 7, 2};
        clear_run();
        @(negedge clk);
        check("reset_outputs", {memRe, memAddr, dataOut, dataValid, busy, done}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int v = 0; v < 6; v++)
            run_xfer(vecs[v].base, vecs[v].n, vecs[v].pat, vecs[v].done_exp, vecs[v].restart);

        clear_run();
        load_expect(3'd0, 4'd8);
        start = 1'b1; baseAddr = 3'd0; len = 4'd8; dataReady = 1'b1;
        sample(0);
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            sample(c);
            check("pre_abort_no_done", 32'(done), 0);
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        exp_q.delete(); addr_q.delete();
        for (int c = 5; c <= 6; c++) begin
            sample(c);
            check("abort_outputs", {memRe, memAddr, dataOut, dataValid, busy, done}, 0);
            @(posedge clk); #1;
        end
        rst_n = 1'b1;
        sample(7);
        check("abort_no_done", {busy, done}, 0);
        @(posedge clk); #1;
        run_xfer(3'd2, 4'd2, 4'hF, 5, 0);

        check("max_occ_le2", 32'(max_occ <= 2), 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1);
    end
endmodule
